// File: rtl/instr_fetch_mem.sv
// Instruction fetch memory: DEPTH x 32-bit word store with a one-deep response register,
// misaligned/out-of-range fault detection and a program-load write port.
module instr_fetch_mem #(
   parameter  int unsigned DEPTH    = 64,
   parameter  int unsigned ADDR_W   = 32,
   parameter  logic [31:0] NOP_WORD = 32'h00000013,
   localparam int unsigned IDX_W    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              req_ready,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_instr,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic [1:0]        rsp_fault,
   input  logic              flush,
   input  logic              ld_en,
   input  logic [IDX_W-1:0]  ld_idx,
   input  logic [31:0]       ld_data
);

   // Declaration initialiser provides the NOP fill in simulation and FPGA power-up.
   logic [31:0]      mem [DEPTH] = '{default: NOP_WORD};

   logic [IDX_W-1:0] idx;
   logic             mis;
   logic             oor;
   logic [1:0]       fault;
   logic             accept;

   assign idx   = req_addr[IDX_W+1:2];
   assign mis   = (req_addr[1:0] != 2'b00);
   assign fault = {oor, mis};

   // No wrap-around: any address bit above the word index is out of range.
   generate
      if (ADDR_W > IDX_W + 2) begin : g_oor
         assign oor = |req_addr[ADDR_W-1:IDX_W+2];
      end else begin : g_no_oor
         assign oor = 1'b0;
      end
   endgenerate

   assign req_ready = (!rsp_valid || rsp_ready) && !ld_en && !flush;
   assign accept    = req_valid && req_ready;

   always_ff @(posedge clk) begin
      if (ld_en) begin
         mem[ld_idx] <= ld_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_instr <= NOP_WORD;
         rsp_addr  <= '0;
         rsp_fault <= '0;
      end else if (flush) begin
         rsp_valid <= 1'b0;
      end else if (accept) begin
         rsp_valid <= 1'b1;
         rsp_addr  <= req_addr;
         rsp_fault <= fault;
         rsp_instr <= (fault != 2'b00) ? NOP_WORD : mem[idx];
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule
